// File: rtl/vga_rtc_pkg.sv
// rtl/vga_rtc_pkg.sv - shared colours, palette and digit encoding for the RTC overlay
package vga_rtc_pkg;

    localparam logic [11:0] BG_COLOR    = 12'h032;
    localparam logic [11:0] ALARM_COLOR = 12'hF00;
    localparam logic [11:0] BLANK_COLOR = 12'h000;
    localparam logic [6:0]  ASCII_ZERO  = 7'h30;
    localparam logic [7:0]  FIELD_NONE  = 8'hFF;
    localparam logic [9:0]  VBLANK_ROW  = 10'd480;

    // Index 0 sits in the rightmost slot of the packed table.
    localparam logic [7:0][11:0] PALETTE = {
        12'h120, 12'h032, 12'h333, 12'h222,
        12'h111, 12'hFFE, 12'h000, 12'h032
    };

    function automatic logic [6:0] bcd_to_ascii(input logic [3:0] nib);
        return ASCII_ZERO + {3'b000, nib};
    endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - free-running blink phase generator with synchronous restart
module blink_timer #(
    parameter int BLINK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    localparam int            CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] count_q;
    logic          phase_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else if (restart) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else if (count_q == LAST) begin
            count_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/vga_rtc_overlay.sv
// rtl/vga_rtc_overlay.sv - RTC digit snapshot, blink and colour priority mux for VGA output
module vga_rtc_overlay
    import vga_rtc_pkg::*;
#(
    parameter int NUM_FIELDS = 11,
    parameter int BLINK_DIV  = 100_000_000,
    parameter int BANNER_TOP = 472,
    parameter int BANNER_BOT = 479
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              pixelx,
    input  logic [9:0]              pixely,
    input  logic                    video_on,
    input  logic [8*NUM_FIELDS-1:0] datos,
    input  logic [7:0]              cursor,
    input  logic                    escribir,
    input  logic                    ring,
    input  logic [7:0]              pixel_field,
    input  logic                    glyph_on,
    input  logic                    graficos,
    input  logic [11:0]             dato_memoria,
    input  logic [2:0]              color_addr,
    output logic [14*NUM_FIELDS-1:0] digits_o,
    output logic [11:0]             rgb_o,
    output logic                    blink_o
);

    localparam logic [8:0] FIELD_LIMIT = 9'(NUM_FIELDS);

    logic [9:0]              pixely_q;
    logic                    hist_vld_q;
    logic                    ring_q;
    logic [8*NUM_FIELDS-1:0] shadow_q, shadow_d;
    logic [11:0]             rgb_q, rgb_d;
    logic                    snap, ring_rise, in_banner, edit_blank, blink;
    logic                    unused_pixelx;

    assign unused_pixelx = ^pixelx;

    // History is only trusted once a full cycle has passed since reset, so a
    // reset released on row 480 cannot fake a 479->480 transition.
    assign snap      = hist_vld_q && (pixely == VBLANK_ROW) && (pixely_q < VBLANK_ROW);
    assign ring_rise = ring && !ring_q;
    assign in_banner = ring && (pixely >= 10'(BANNER_TOP)) && (pixely <= 10'(BANNER_BOT));
    assign edit_blank = escribir && blink && (pixel_field != FIELD_NONE)
                      && ({1'b0, cursor} < FIELD_LIMIT) && (pixel_field == cursor);
    assign shadow_d  = snap ? datos : shadow_q;

    blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk     (clk),
        .reset   (reset),
        .restart (ring_rise),
        .phase   (blink)
    );

    always_comb begin
        rgb_d = glyph_on ? PALETTE[color_addr] : BG_COLOR;
        if (!video_on)
            rgb_d = BLANK_COLOR;
        else if (graficos)
            rgb_d = dato_memoria;
        else if (in_banner)
            rgb_d = blink ? ALARM_COLOR : PALETTE[color_addr];
        else if (edit_blank)
            rgb_d = BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixely_q   <= '0;
            hist_vld_q <= 1'b0;
            ring_q     <= 1'b0;
            shadow_q   <= '0;
            rgb_q      <= BLANK_COLOR;
        end else begin
            pixely_q   <= pixely;
            hist_vld_q <= 1'b1;
            ring_q     <= ring;
            shadow_q   <= shadow_d;
            rgb_q      <= rgb_d;
        end
    end

    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_digit
        assign digits_o[14*k +: 7]   = bcd_to_ascii(shadow_q[8*k +: 4]);
        assign digits_o[14*k+7 +: 7] = bcd_to_ascii(shadow_q[8*k+4 +: 4]);
    end

    assign rgb_o   = rgb_q;
    assign blink_o = blink;

endmodule

// File: tb/tb_vga_rtc_overlay.sv
// tb/tb_vga_rtc_overlay.sv - self-checking bench for vga_rtc_overlay against a behavioural model
module tb_vga_rtc_overlay;

    localparam int NF  = 11;
    localparam int DIV = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [9:0]      pixelx = '0;
    logic [9:0]      pixely = '0;
    logic            video_on = 1'b0;
    logic [8*NF-1:0] datos = '0;
    logic [7:0]      cursor = '0;
    logic            escribir = 1'b0;
    logic            ring = 1'b0;
    logic [7:0]      pixel_field = 8'hFF;
    logic            glyph_on = 1'b0;
    logic            graficos = 1'b0;
    logic [11:0]     dato_memoria = '0;
    logic [2:0]      color_addr = '0;
    logic [14*NF-1:0] digits_o;
    logic [11:0]     rgb_o;
    logic            blink_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_field [NF];
    int          m_prev_y;
    bit          m_hist;
    bit          m_ring_prev;
    int          m_since;
    logic [11:0] m_rgb;

    always #5 clk = ~clk;

    vga_rtc_overlay #(.NUM_FIELDS(NF), .BLINK_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixelx       (pixelx),
        .pixely       (pixely),
        .video_on     (video_on),
        .datos        (datos),
        .cursor       (cursor),
        .escribir     (escribir),
        .ring         (ring),
        .pixel_field  (pixel_field),
        .glyph_on     (glyph_on),
        .graficos     (graficos),
        .dato_memoria (dato_memoria),
        .color_addr   (color_addr),
        .digits_o     (digits_o),
        .rgb_o        (rgb_o),
        .blink_o      (blink_o)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pal(input int idx);
        case (idx)
            0: return 12'h032;
            1: return 12'h000;
            2: return 12'hFFE;
            3: return 12'h111;
            4: return 12'h222;
            5: return 12'h333;
            6: return 12'h032;
            default: return 12'h120;
        endcase
    endfunction

    function automatic bit m_phase();
        return ((m_since / DIV) % 2) == 1;
    endfunction

    function automatic logic [14*NF-1:0] exp_digits();
        logic [14*NF-1:0] v;
        v = '0;
        for (int k = 0; k < NF; k++) begin
            v[14*k +: 7]   = 7'(48 + int'(m_field[k]) % 16);
            v[14*k+7 +: 7] = 7'(48 + int'(m_field[k]) / 16);
        end
        return v;
    endfunction

    function automatic logic [11:0] ref_rgb(input bit phase);
        if (!video_on) return 12'h000;
        if (graficos) return dato_memoria;
        if (ring && pixely >= 472 && pixely <= 479) return phase ? 12'hF00 : pal(int'(color_addr));
        if (escribir && int'(cursor) < NF && pixel_field == cursor && phase) return 12'h032;
        if (glyph_on) return pal(int'(color_addr));
        return 12'h032;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NF; k++) m_field[k] = 8'h00;
        m_prev_y    = 0;
        m_hist      = 0;
        m_ring_prev = 0;
        m_since     = 0;
        m_rgb       = 12'h000;
    endtask

    task automatic cycle();
        logic [11:0] nxt;
        bit          snap;
        nxt  = ref_rgb(m_phase());
        snap = m_hist && int'(pixely) == 480 && m_prev_y < 480;
        @(posedge clk);
        #1;
        m_rgb = nxt;
        if (snap)
            for (int k = 0; k < NF; k++) m_field[k] = datos[8*k +: 8];
        m_prev_y = int'(pixely);
        m_hist   = 1;
        if (ring && !m_ring_prev) m_since = 0;
        else m_since++;
        m_ring_prev = ring;
        check("rgb", 160'(rgb_o), 160'(m_rgb));
        check("blink", 160'(blink_o), 160'(m_phase()));
        check("digits", 160'(digits_o), 160'(exp_digits()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_digits", 160'(digits_o), 160'({(2*NF){7'h30}}));
        check("rst_rgb", 160'(rgb_o), 160'(12'h000));
        check("rst_blink", 160'(blink_o), 160'(1'b0));
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_digits", 160'(digits_o), 160'({(2*NF){7'h30}}));
        check("init_rgb", 160'(rgb_o), 160'(12'h000));
        check("init_blink", 160'(blink_o), 160'(1'b0));
        @(negedge clk);
        reset = 1'b1;

        // Snapshot on the 479->480 transition, then hold while datos changes
        datos[7:0] = 8'h59;
        pixely = 10'd479; cycle();
        pixely = 10'd480; cycle();
        check("snap_f0", 160'(digits_o[13:0]), 160'({7'h35, 7'h39}));
        pixely = 10'd100; datos[7:0] = 8'h12; cycle();
        check("hold_f0", 160'(digits_o[13:0]), 160'({7'h35, 7'h39}));

        video_on = 1'b1; glyph_on = 1'b1; color_addr = 3'd2; cycle();
        check("glyph_pal2", 160'(rgb_o), 160'(12'hFFE));
        video_on = 1'b0; cycle();
        check("video_off", 160'(rgb_o), 160'(12'h000));
        video_on = 1'b1;

        // Alarm banner: restart phase on ring rise, 8 cycles per half period
        glyph_on = 1'b0; color_addr = 3'd1; pixely = 10'd475; ring = 1'b0; cycle();
        ring = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            if (k >= 2) check("banner", 160'(rgb_o), 160'((((k - 2) / 8) % 2 == 1) ? 12'hF00 : 12'h000));
        end
        graficos = 1'b1; dato_memoria = 12'hABC; cycle();
        check("gfx_over_banner", 160'(rgb_o), 160'(12'hABC));
        graficos = 1'b0; pixely = 10'd400; cycle();
        check("no_banner", 160'(rgb_o), 160'(12'h032));

        // Edit blanking of the cursor field only
        ring = 1'b0; escribir = 1'b1; cursor = 8'd3; pixel_field = 8'd3; glyph_on = 1'b1; color_addr = 3'd2;
        for (int k = 0; k < 20; k++) begin
            bit ph;
            ph = m_phase();
            cycle();
            check("edit_blank", 160'(rgb_o), 160'(ph ? 12'h032 : 12'hFFE));
        end
        pixel_field = 8'd4;
        for (int k = 0; k < 10; k++) begin cycle(); check("edit_other", 160'(rgb_o), 160'(12'hFFE)); end
        cursor = 8'd11; pixel_field = 8'd11;
        for (int k = 0; k < 10; k++) begin cycle(); check("edit_range", 160'(rgb_o), 160'(12'hFFE)); end
        escribir = 1'b0;

        // Reset landing on the snapshot row suppresses that snapshot
        datos[7:0] = 8'h59; pixely = 10'd479; cycle();
        pixely = 10'd480;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("no_snap_after_rst", 160'(digits_o), 160'({(2*NF){7'h30}}));
        end
        pixely = 10'd479; cycle();
        pixely = 10'd480; cycle();
        check("snap_next_frame", 160'(digits_o[13:0]), 160'({7'h35, 7'h39}));

        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 5));
            if (r < 3) pixely = (pixely >= 10'd476 && pixely < 10'd482) ? pixely + 10'd1 : 10'd476;
            else if (r == 3) pixely = 10'(470 + $urandom_range(0, 11));
            else pixely = 10'($urandom_range(0, 524));
            pixelx = 10'($urandom_range(0, 799));
            datos[8*$urandom_range(0, NF-1) +: 8] = 8'($urandom);
            video_on     = ($urandom_range(0, 9) != 0);
            graficos     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) ring = ~ring;
            escribir     = 1'($urandom);
            cursor       = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
            pixel_field  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
            glyph_on     = 1'($urandom);
            color_addr   = 3'($urandom);
            dato_memoria = 12'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
